// File: rtl/bus_pkg.sv
// Shared definitions for the arbitrated bus slave side: widths, address map
// and the responder state encoding.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] SLV_BASE0  = 32'hFFEF_0200;
  localparam logic [ADDR_W-1:0] SLV_STRIDE = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } slv_state_t;

  // Window base for a given slave index; the index bits never overlap SLV_BASE0.
  function automatic logic [ADDR_W-1:0] slv_base(input int unsigned slv_id);
    return SLV_BASE0 | (SLV_STRIDE * ADDR_W'(slv_id));
  endfunction

endpackage

// File: rtl/slv_regbank.sv
// Four 32-bit slave registers, one per master offset: synchronous write,
// combinational read, cleared on reset.
module slv_regbank
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs_q [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= '0;
        end else if (we && (idx == 2'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs_q[gi] = q_reg;
    end
  endgenerate

  assign rdata = regs_q[idx];

endmodule

// File: rtl/bus_slave_resp.sv
// Target end of one arbitrated slave port: decodes its address window, inserts
// WAIT_CYC wait states, then completes a register read/write with a ready pulse.
module bus_slave_resp
  import bus_pkg::*;
#(
  parameter int unsigned SLV_ID   = 0,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] DataToSlave,
  output logic [DATA_W-1:0] DataFromSlave,
  output logic              ready,
  output logic              err,
  output logic [15:0]       access_cnt
);

  localparam logic [ADDR_W-1:0] BASE      = slv_base(SLV_ID);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYC);

  slv_state_t        state_reg;
  logic [3:0]        wcnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              rw_reg;
  // Set once sel has been sampled low; a transfer may only start while armed,
  // so a select held high across reset or HOLD cannot retrigger.
  logic              armed_reg;

  logic              hit;
  logic [1:0]        idx;
  logic              bank_we;
  logic [DATA_W-1:0] bank_rdata;

  assign hit     = (addr_reg[ADDR_W-1:6] == BASE[ADDR_W-1:6]) && (addr_reg[3:0] == 4'h0);
  assign idx     = addr_reg[5:4];
  assign bank_we = (state_reg == ACCESS) && hit && rw_reg;

  slv_regbank u_regbank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .idx   (idx),
    .wdata (data_reg),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wcnt_reg      <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      rw_reg        <= 1'b0;
      armed_reg     <= 1'b0;
      DataFromSlave <= '0;
      ready         <= 1'b0;
      err           <= 1'b0;
      access_cnt    <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!sel) begin
            armed_reg <= 1'b1;
          end else if (armed_reg) begin
            addr_reg  <= addr;
            data_reg  <= DataToSlave;
            rw_reg    <= RW;
            wcnt_reg  <= WAIT_INIT;
            armed_reg <= 1'b0;
            state_reg <= (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (!sel) begin
            armed_reg <= 1'b1;
            state_reg <= IDLE;
          end else begin
            wcnt_reg <= wcnt_reg - 4'd1;
            if (wcnt_reg == 4'd1) state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          ready <= 1'b1;
          err   <= !hit;
          if (!rw_reg) DataFromSlave <= hit ? bank_rdata : '0;
          if (hit && (access_cnt != 16'hFFFF)) access_cnt <= access_cnt + 16'd1;
          state_reg <= HOLD;
        end
        HOLD: begin
          if (!sel) begin
            armed_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
